branch_redirect_arb: RTL and testbench

BRANCH_REDIRECT_ARB -- requirements
Module: branch_redirect_arb

---
 rtl/branch_redirect_arb_pkg.sv | 33 +++
 rtl/branch_redirect_arb_if.sv | 59 +++++
 rtl/branch_redirect_arb_rob_age_cmp.sv | 26 ++
 rtl/branch_redirect_arb.sv | 188 ++++++++++++++++++
 tb/tb_branch_redirect_arb.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_redirect_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_redirect_pkg
//  Purpose  : Shared defaults and the redirect record type for the branch
//             redirect arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package branch_redirect_pkg;

  localparam int DEFAULT_NUM_IN    = 2;
  localparam int DEFAULT_ROB_IDX_W = 5;
  localparam int DEFAULT_FTQ_IDX_W = 3;

  typedef struct packed {
    logic                         flag;
    logic [DEFAULT_ROB_IDX_W-1:0] value;
  } rob_idx_t;

  typedef struct packed {
    logic                         flag;
    logic [DEFAULT_FTQ_IDX_W-1:0] value;
  } ftq_idx_t;

  // One redirect as seen by the frontend, at default widths.
  typedef struct packed {
    rob_idx_t                     rob;
    ftq_idx_t                     ftq;
    logic [DEFAULT_FTQ_IDX_W-1:0] ftq_offset;
    logic                         taken;
  } redirect_t;

endpackage
`default_nettype wire

// File: rtl/branch_redirect_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_redirect_arb_if
//  Purpose  : ALU redirect sources, backend flush and frontend redirect
//             channel for the branch redirect arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_redirect_arb_if #(
  parameter int NUM_IN    = branch_redirect_pkg::DEFAULT_NUM_IN,
  parameter int ROB_IDX_W = branch_redirect_pkg::DEFAULT_ROB_IDX_W,
  parameter int FTQ_IDX_W = branch_redirect_pkg::DEFAULT_FTQ_IDX_W
);
  import branch_redirect_pkg::*;

  // ALU redirect sources
  logic [NUM_IN-1:0]                in_valid;
  logic [NUM_IN-1:0]                in_robIdx_flag;
  logic [NUM_IN-1:0][ROB_IDX_W-1:0] in_robIdx_value;
  logic [NUM_IN-1:0]                in_ftqIdx_flag;
  logic [NUM_IN-1:0][FTQ_IDX_W-1:0] in_ftqIdx_value;
  logic [NUM_IN-1:0][FTQ_IDX_W-1:0] in_ftqOffset;
  logic [NUM_IN-1:0]                in_taken;
  logic [NUM_IN-1:0]                in_isMisPred;

  // Backend flush
  logic                 flush_valid;
  logic                 flush_robIdx_flag;
  logic [ROB_IDX_W-1:0] flush_robIdx_value;

  // Redirect to frontend
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_robIdx_flag;
  logic [ROB_IDX_W-1:0] out_robIdx_value;
  logic                 out_ftqIdx_flag;
  logic [FTQ_IDX_W-1:0] out_ftqIdx_value;
  logic [FTQ_IDX_W-1:0] out_ftqOffset;
  logic                 out_taken;

  // Environment side: drives sources, flush and ready
  modport master (
    output in_valid, in_robIdx_flag, in_robIdx_value, in_ftqIdx_flag,
           in_ftqIdx_value, in_ftqOffset, in_taken, in_isMisPred,
           flush_valid, flush_robIdx_flag, flush_robIdx_value, out_ready,
    input  out_valid, out_robIdx_flag, out_robIdx_value, out_ftqIdx_flag,
           out_ftqIdx_value, out_ftqOffset, out_taken
  );

  // Arbiter side
  modport slave (
    input  in_valid, in_robIdx_flag, in_robIdx_value, in_ftqIdx_flag,
           in_ftqIdx_value, in_ftqOffset, in_taken, in_isMisPred,
           flush_valid, flush_robIdx_flag, flush_robIdx_value, out_ready,
    output out_valid, out_robIdx_flag, out_robIdx_value, out_ftqIdx_flag,
           out_ftqIdx_value, out_ftqOffset, out_taken
  );

endinterface
`default_nettype wire

// File: rtl/branch_redirect_arb_rob_age_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : rob_age_cmp
//  Purpose  : Combinational ROB age compare. older_o is set when A is
//             strictly older than B; the flag bit marks which lap of the
//             circular ROB an index belongs to, so a flag mismatch inverts
//             the value compare. Equal indices are never older.
//  Revision : 1.0 - initial release
// ============================================================================
module rob_age_cmp
  import branch_redirect_pkg::*;
#(
  parameter int ROB_IDX_W = DEFAULT_ROB_IDX_W
) (
  input  logic                 a_flag_i,
  input  logic [ROB_IDX_W-1:0] a_value_i,
  input  logic                 b_flag_i,
  input  logic [ROB_IDX_W-1:0] b_value_i,
  output logic                 older_o
);

  assign older_o = (a_flag_i == b_flag_i) ? (a_value_i < b_value_i)
                                          : (a_value_i > b_value_i);

endmodule
`default_nettype wire

// File: rtl/branch_redirect_arb.sv
`default_nettype none
// ============================================================================
//  Module   : branch_redirect_arb
//  Purpose  : Picks the oldest mispredicting ALU redirect each cycle and
//             holds it in a single-entry register until the frontend takes
//             it. An older arrival replaces the held entry; backend flushes
//             kill both incoming and held redirects.
//  Options  : BRANCH_REDIRECT_ARB_PERF_EN adds saturating perf_issued /
//             perf_dropped counters.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_arb
  import branch_redirect_pkg::*;
#(
  parameter int NUM_IN    = DEFAULT_NUM_IN,
  parameter int ROB_IDX_W = DEFAULT_ROB_IDX_W,
  parameter int FTQ_IDX_W = DEFAULT_FTQ_IDX_W
) (
  input  logic clock,
  input  logic reset_n,
  branch_redirect_arb_if.slave bus
`ifdef BRANCH_REDIRECT_ARB_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_dropped
`endif
);

  // Same field order as redirect_t, sized by this instance's parameters.
  typedef struct packed {
    logic                 rob_flag;
    logic [ROB_IDX_W-1:0] rob_value;
    logic                 ftq_flag;
    logic [FTQ_IDX_W-1:0] ftq_value;
    logic [FTQ_IDX_W-1:0] ftq_offset;
    logic                 taken;
  } entry_t;

  entry_t            w_in [NUM_IN];
  logic              w_older [NUM_IN][NUM_IN];
  logic [NUM_IN-1:0] w_in_vs_flush;
  logic [NUM_IN-1:0] w_qual;
  logic [NUM_IN-1:0] w_win;
  entry_t            w_cand;
  logic              w_cand_vld;
  logic              w_cand_older;
  logic              w_held_vs_flush;
  logic              w_xfer, w_held_kill, w_held_live, w_load;

  logic              valid_q, valid_d;
  entry_t            entry_q, entry_d;

  // Per-source qualification and the full pairwise age matrix.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_src
    assign w_in[i] = {bus.in_robIdx_flag[i], bus.in_robIdx_value[i],
                      bus.in_ftqIdx_flag[i], bus.in_ftqIdx_value[i],
                      bus.in_ftqOffset[i], bus.in_taken[i]};

    rob_age_cmp #(.ROB_IDX_W(ROB_IDX_W)) u_flush_cmp (
      .a_flag_i (bus.in_robIdx_flag[i]),
      .a_value_i(bus.in_robIdx_value[i]),
      .b_flag_i (bus.flush_robIdx_flag),
      .b_value_i(bus.flush_robIdx_value),
      .older_o  (w_in_vs_flush[i])
    );

    // A source survives a flush only if it is strictly older than the flush point.
    assign w_qual[i] = bus.in_valid[i] & bus.in_isMisPred[i]
                     & ~(bus.flush_valid & ~w_in_vs_flush[i]);

    for (genvar j = 0; j < NUM_IN; j++) begin : g_pair
      if (i != j) begin : g_cmp
        rob_age_cmp #(.ROB_IDX_W(ROB_IDX_W)) u_pair_cmp (
          .a_flag_i (bus.in_robIdx_flag[i]),
          .a_value_i(bus.in_robIdx_value[i]),
          .b_flag_i (bus.in_robIdx_flag[j]),
          .b_value_i(bus.in_robIdx_value[j]),
          .older_o  (w_older[i][j])
        );
      end else begin : g_self
        assign w_older[i][j] = 1'b0;
      end
    end
  end

  // Source i wins if it beats every other qualifying source; ties go to the lower index.
  always_comb begin
    w_win      = '0;
    w_cand     = '0;
    w_cand_vld = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_win[i] = w_qual[i];
      for (int j = 0; j < NUM_IN; j++) begin
        if (j != i && w_qual[j] &&
            !(w_older[i][j] || (!w_older[j][i] && i < j))) begin
          w_win[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_win[i] && !w_cand_vld) begin
        w_cand     = w_in[i];
        w_cand_vld = 1'b1;
      end
    end
  end

  rob_age_cmp #(.ROB_IDX_W(ROB_IDX_W)) u_held_flush_cmp (
    .a_flag_i (entry_q.rob_flag),
    .a_value_i(entry_q.rob_value),
    .b_flag_i (bus.flush_robIdx_flag),
    .b_value_i(bus.flush_robIdx_value),
    .older_o  (w_held_vs_flush)
  );

  rob_age_cmp #(.ROB_IDX_W(ROB_IDX_W)) u_cand_held_cmp (
    .a_flag_i (w_cand.rob_flag),
    .a_value_i(w_cand.rob_value),
    .b_flag_i (entry_q.rob_flag),
    .b_value_i(entry_q.rob_value),
    .older_o  (w_cand_older)
  );

  // The held entry stays only if it is neither taken nor flushed this cycle.
  assign w_xfer      = valid_q & bus.out_ready;
  assign w_held_kill = valid_q & bus.flush_valid & ~w_held_vs_flush;
  assign w_held_live = valid_q & ~w_held_kill & ~w_xfer;
  assign w_load      = w_cand_vld & (~w_held_live | w_cand_older);
  assign valid_d     = w_load | w_held_live;
  assign entry_d     = w_load ? w_cand : entry_q;

  // Holding register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign bus.out_valid        = valid_q;
  assign bus.out_robIdx_flag  = entry_q.rob_flag;
  assign bus.out_robIdx_value = entry_q.rob_value;
  assign bus.out_ftqIdx_flag  = entry_q.ftq_flag;
  assign bus.out_ftqIdx_value = entry_q.ftq_value;
  assign bus.out_ftqOffset    = entry_q.ftq_offset;
  assign bus.out_taken        = entry_q.taken;

`ifdef BRANCH_REDIRECT_ARB_PERF_EN
  localparam logic [31:0] C_SAT = 32'hFFFF_FFFF;

  logic [31:0] perf_issued_q, perf_dropped_q;
  logic [31:0] w_qual_cnt, w_drop_inc;

  // Qualifying candidates that did not make it into the register this cycle.
  always_comb begin
    w_qual_cnt = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_qual_cnt = w_qual_cnt + 32'(w_qual[i]);
    end
    w_drop_inc = w_qual_cnt - 32'(w_load);
  end

  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_issued_q  <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (w_xfer && perf_issued_q != C_SAT) begin
        perf_issued_q <= perf_issued_q + 32'd1;
      end
      if (perf_dropped_q > (C_SAT - w_drop_inc)) begin
        perf_dropped_q <= C_SAT;
      end else begin
        perf_dropped_q <= perf_dropped_q + w_drop_inc;
      end
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_redirect_arb
//  Purpose  : Directed bench for branch_redirect_arb.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_arb;
  import branch_redirect_pkg::*;

  logic clock;
  logic reset_n;
  int   total  = 0;
  int   passed = 0;

  branch_redirect_arb_if #(.NUM_IN(2), .ROB_IDX_W(5), .FTQ_IDX_W(3)) bus ();

`ifdef BRANCH_REDIRECT_ARB_PERF_EN
  logic [31:0] perf_issued, perf_dropped;
`endif

  branch_redirect_arb #(.NUM_IN(2), .ROB_IDX_W(5), .FTQ_IDX_W(3)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus)
`ifdef BRANCH_REDIRECT_ARB_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_dropped(perf_dropped)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic redirect_t mk(input logic rf, input logic [4:0] rv, input logic ff,
                                   input logic [2:0] fv, input logic [2:0] off, input logic tk);
    redirect_t r;
    r.rob.flag   = rf;
    r.rob.value  = rv;
    r.ftq.flag   = ff;
    r.ftq.value  = fv;
    r.ftq_offset = off;
    r.taken      = tk;
    return r;
  endfunction

  function automatic redirect_t obs_out();
    return mk(bus.out_robIdx_flag, bus.out_robIdx_value, bus.out_ftqIdx_flag,
              bus.out_ftqIdx_value, bus.out_ftqOffset, bus.out_taken);
  endfunction

  task automatic set_src(input int s, input logic rf, input logic [4:0] rv, input logic ff,
                         input logic [2:0] fv, input logic [2:0] off, input logic tk,
                         input logic mp);
    bus.in_valid[s]        = 1'b1;
    bus.in_robIdx_flag[s]  = rf;
    bus.in_robIdx_value[s] = rv;
    bus.in_ftqIdx_flag[s]  = ff;
    bus.in_ftqIdx_value[s] = fv;
    bus.in_ftqOffset[s]    = off;
    bus.in_taken[s]        = tk;
    bus.in_isMisPred[s]    = mp;
  endtask

  task automatic flush(input logic rf, input logic [4:0] rv);
    bus.flush_valid        = 1'b1;
    bus.flush_robIdx_flag  = rf;
    bus.flush_robIdx_value = rv;
  endtask

  task automatic clr();
    bus.in_valid     = '0;
    bus.in_isMisPred = '0;
    bus.flush_valid  = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n                = 1'b0;
    bus.out_ready          = 1'b0;
    bus.in_valid           = '0;
    bus.in_robIdx_flag     = '0;
    bus.in_robIdx_value    = '0;
    bus.in_ftqIdx_flag     = '0;
    bus.in_ftqIdx_value    = '0;
    bus.in_ftqOffset       = '0;
    bus.in_taken           = '0;
    bus.in_isMisPred       = '0;
    bus.flush_valid        = 1'b0;
    bus.flush_robIdx_flag  = 1'b0;
    bus.flush_robIdx_value = '0;

    // Reset state
    step(); step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(obs_out()), 32'd0);
    reset_n = 1'b1;
    step();
    check("idle_valid", 32'(bus.out_valid), 32'd0);

    // Oldest of two mispredicts selected, one cycle later
    bus.out_ready = 1'b1;
    set_src(0, 0, 5'd7, 0, 3'd1, 3'd2, 1, 1);
    set_src(1, 0, 5'd3, 1, 3'd5, 3'd6, 0, 1);
    step();
    check("sel_valid", 32'(bus.out_valid), 32'd1);
    check("sel_oldest", 32'(obs_out()), 32'(mk(0, 5'd3, 1, 3'd5, 3'd6, 0)));
    clr();
    step();
    check("xfer_frees", 32'(bus.out_valid), 32'd0);

    // Equal robIdx: lower source index wins
    set_src(0, 0, 5'd6, 0, 3'd2, 3'd1, 1, 1);
    set_src(1, 0, 5'd6, 1, 3'd3, 3'd4, 0, 1);
    step();
    check("tie_low_idx", 32'(obs_out()), 32'(mk(0, 5'd6, 0, 3'd2, 3'd1, 1)));
    clr();
    step();

    // Valid but not mispredicted: nothing issued
    set_src(0, 0, 5'd1, 0, 3'd0, 3'd0, 0, 0);
    step();
    check("nomispred", 32'(bus.out_valid), 32'd0);
`ifdef BRANCH_REDIRECT_ARB_PERF_EN
    check("perf_issued", perf_issued, 32'd2);
    check("perf_dropped", perf_dropped, 32'd2);
`endif
    clr();

    // Held entry: older replaces, younger and equal are dropped
    bus.out_ready = 1'b0;
    set_src(0, 0, 5'd10, 0, 3'd1, 3'd3, 1, 1);
    step();
    check("hold_valid", 32'(bus.out_valid), 32'd1);
    check("hold_10", 32'(obs_out()), 32'(mk(0, 5'd10, 0, 3'd1, 3'd3, 1)));
    clr();
    set_src(0, 0, 5'd4, 0, 3'd2, 3'd5, 0, 1);
    step();
    check("replace_4", 32'(obs_out()), 32'(mk(0, 5'd4, 0, 3'd2, 3'd5, 0)));
    clr();
    set_src(1, 0, 5'd12, 1, 3'd7, 3'd7, 1, 1);
    step();
    check("drop_12", 32'(obs_out()), 32'(mk(0, 5'd4, 0, 3'd2, 3'd5, 0)));
    clr();
    set_src(0, 0, 5'd4, 1, 3'd1, 3'd1, 1, 1);
    step();
    check("drop_equal", 32'(obs_out()), 32'(mk(0, 5'd4, 0, 3'd2, 3'd5, 0)));
    clr();
    step();
    check("stable_valid", 32'(bus.out_valid), 32'd1);
    check("stable_data", 32'(obs_out()), 32'(mk(0, 5'd4, 0, 3'd2, 3'd5, 0)));
    bus.out_ready = 1'b1;
    step();
    check("hold_xfer", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Wrap: (1,0) is younger than (0,31)
    set_src(0, 0, 5'd31, 0, 3'd3, 3'd2, 1, 1);
    step();
    check("wrap_load", 32'(obs_out()), 32'(mk(0, 5'd31, 0, 3'd3, 3'd2, 1)));
    clr();
    set_src(1, 1, 5'd0, 1, 3'd4, 3'd4, 0, 1);
    step();
    check("wrap_keep", 32'(obs_out()), 32'(mk(0, 5'd31, 0, 3'd3, 3'd2, 1)));
    clr();
    flush(0, 5'd31);
    step();
    check("flush_eq_kill", 32'(bus.out_valid), 32'd0);
    clr();
    // Reverse wrap: (0,31) is older than held (1,0)
    set_src(0, 1, 5'd0, 0, 3'd0, 3'd1, 0, 1);
    step();
    clr();
    set_src(1, 0, 5'd31, 0, 3'd5, 3'd3, 1, 1);
    step();
    check("wrap_replace", 32'(obs_out()), 32'(mk(0, 5'd31, 0, 3'd5, 3'd3, 1)));
    clr();
    flush(0, 5'd31);
    step();
    clr();

    // Flush of held entry with and without a surviving candidate
    set_src(0, 0, 5'd9, 0, 3'd6, 3'd0, 1, 1);
    step();
    check("held_9", 32'(obs_out()), 32'(mk(0, 5'd9, 0, 3'd6, 3'd0, 1)));
    clr();
    flush(0, 5'd9);
    set_src(1, 0, 5'd2, 1, 3'd2, 3'd1, 0, 1);
    step();
    check("flush_reload_v", 32'(bus.out_valid), 32'd1);
    check("flush_reload", 32'(obs_out()), 32'(mk(0, 5'd2, 1, 3'd2, 3'd1, 0)));
    clr();
    flush(0, 5'd2);
    step();
    check("flush_clear_2", 32'(bus.out_valid), 32'd0);
    clr();
    set_src(0, 0, 5'd9, 0, 3'd6, 3'd0, 1, 1);
    step();
    clr();
    flush(0, 5'd9);
    step();
    check("flush_clear_9", 32'(bus.out_valid), 32'd0);
    clr();

    // Flush also kills incoming sources at or younger than the flush point
    flush(0, 5'd5);
    set_src(0, 0, 5'd8, 0, 3'd1, 3'd1, 1, 1);
    step();
    check("flush_kill_in", 32'(bus.out_valid), 32'd0);
    flush(0, 5'd5);
    set_src(0, 0, 5'd8, 0, 3'd1, 3'd1, 1, 1);
    set_src(1, 0, 5'd4, 0, 3'd7, 3'd6, 0, 1);
    step();
    check("flush_survivor", 32'(obs_out()), 32'(mk(0, 5'd4, 0, 3'd7, 3'd6, 0)));
    clr();

    // Reset while holding with ready low
    reset_n = 1'b0;
    step();
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_data", 32'(obs_out()), 32'd0);
    reset_n = 1'b1;
    step();
    check("postrst_valid", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
